// File: rtl/imem_pkg.sv
// imem_pkg: shared FSM state encoding and default sizing for the instruction-memory loader.
package imem_pkg;
    localparam int IMEM_DEF_CAPACITY = 512;
    localparam int IMEM_DEF_WIDTH    = 32;
    typedef logic [1:0] imem_state_t;
    localparam imem_state_t ST_IDLE = 2'd0;
    localparam imem_state_t ST_LOAD = 2'd1;
    localparam imem_state_t ST_DONE = 2'd2;
endpackage

// File: rtl/imem_array.sv
// imem_array: instruction storage with one synchronous write port and one registered read port.
module imem_array
    import imem_pkg::*;
#(
    parameter int  CAPACITY   = IMEM_DEF_CAPACITY,
    parameter int  BUS_WIDTH  = IMEM_DEF_WIDTH,
    localparam int ADDR_WIDTH = $clog2(CAPACITY)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [BUS_WIDTH-1:0]  wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [BUS_WIDTH-1:0]  rd_data,
    output logic                  rd_valid,
    output logic                  rd_oob
);
    localparam logic [ADDR_WIDTH:0] CAP = (ADDR_WIDTH + 1)'(CAPACITY);
    logic [BUS_WIDTH-1:0] mem [CAPACITY];
    logic rd_in, wr_in;
    assign rd_in = {1'b0, rd_addr} < CAP;
    assign wr_in = {1'b0, wr_addr} < CAP;
    // Storage is deliberately left out of reset so a reset mid-load keeps written words.
    always_ff @(posedge clk) begin
        if (wr_en && wr_in) mem[wr_addr] <= wr_data;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_oob   <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            rd_oob   <= rd_en && !rd_in;
            if (rd_en) rd_data <= rd_in ? mem[rd_addr] : '0;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a burst of words into instruction memory while serving fetches.
// Optional XOR checksum of each burst is built only when IMEM_LOAD_CSUM_EN is defined.
module imem_loader
    import imem_pkg::*;
#(
    parameter int  CAPACITY   = IMEM_DEF_CAPACITY,
    parameter int  BUS_WIDTH  = IMEM_DEF_WIDTH,
    localparam int ADDR_WIDTH = $clog2(CAPACITY)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [ADDR_WIDTH:0]   load_count,
    input  logic                  load_abort,
    input  logic                  s_valid,
    input  logic [BUS_WIDTH-1:0]  s_data,
    output logic                  s_ready,
    output logic                  load_busy,
    output logic                  load_done,
    output logic [BUS_WIDTH-1:0]  load_csum,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [BUS_WIDTH-1:0]  read_data,
    output logic                  read_valid,
    output logic                  read_oob
);
    imem_state_t           state;
    logic [ADDR_WIDTH-1:0] wptr, wptr_nxt;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  beat, start;
    assign s_ready   = state == ST_LOAD;
    assign load_busy = state == ST_LOAD;
    assign load_done = state == ST_DONE;
    assign beat      = s_valid && s_ready;
    assign start     = load_start && state == ST_IDLE;
    // Explicit wrap so non-power-of-two capacities never address past the end.
    assign wptr_nxt  = wptr == ADDR_WIDTH'(CAPACITY - 1) ? '0 : wptr + 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wptr      <= '0;
            remaining <= '0;
        end else if (start) begin
            wptr      <= load_base;
            remaining <= load_count;
            state     <= load_count == '0 ? ST_DONE : ST_LOAD;
        end else if (state == ST_LOAD) begin
            if (beat) begin
                wptr      <= wptr_nxt;
                remaining <= remaining - 1'b1;
            end
            if (load_abort) state <= ST_IDLE;
            else if (beat && remaining == (ADDR_WIDTH + 1)'(1)) state <= ST_DONE;
        end else if (state != ST_IDLE) begin
            state <= ST_IDLE;
        end
    end
`ifdef IMEM_LOAD_CSUM_EN
    logic [BUS_WIDTH-1:0] csum;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) csum <= '0;
        else if (start) csum <= '0;
        else if (beat) csum <= csum ^ s_data;
    end
    assign load_csum = csum;
`else
    assign load_csum = '0;
`endif
    imem_array #(.CAPACITY(CAPACITY), .BUS_WIDTH(BUS_WIDTH)) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (beat),
        .wr_addr (wptr),
        .wr_data (s_data),
        .rd_en   (read_en),
        .rd_addr (read_addr),
        .rd_data (read_data),
        .rd_valid(read_valid),
        .rd_oob  (read_oob)
    );
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: self-checking bench for imem_loader on a non-power-of-two capacity.
module tb_imem_loader;
    localparam int CAP = 10;
    localparam int W   = 32;
    localparam int AW  = $clog2(CAP);

    logic          clk, rst_n, load_start, load_abort, s_valid, s_ready;
    logic          load_busy, load_done, read_en, read_valid, read_oob;
    logic [AW-1:0] load_base, read_addr;
    logic [AW:0]   load_count;
    logic [W-1:0]  s_data, load_csum, read_data;

    imem_loader #(.CAPACITY(CAP), .BUS_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_base(load_base),
        .load_count(load_count), .load_abort(load_abort), .s_valid(s_valid),
        .s_data(s_data), .s_ready(s_ready), .load_busy(load_busy), .load_done(load_done),
        .load_csum(load_csum), .read_en(read_en), .read_addr(read_addr),
        .read_data(read_data), .read_valid(read_valid), .read_oob(read_oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [W-1:0] data;
        logic        oob;
    } fetch_vec_t;

    fetch_vec_t   tab [6];
    logic [W-1:0] ref_mem [CAP];
    logic [W-1:0] ref_csum;
    logic [W-1:0] word_src [$];
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] exp_csum();
`ifdef IMEM_LOAD_CSUM_EN
        return ref_csum;
`else
        return '0;
`endif
    endfunction

    task automatic fetch(input int a, input logic [W-1:0] exp_d, input logic exp_oob, input string tag);
        read_en   = 1'b1;
        read_addr = AW'(a);
        step();
        read_en   = 1'b0;
        check($sformatf("%s valid @%0d", tag, a), read_valid, 1);
        check($sformatf("%s data @%0d", tag, a), read_data, exp_d);
        check($sformatf("%s oob @%0d", tag, a), read_oob, exp_oob);
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < CAP; a++) fetch(a, ref_mem[a], 1'b0, tag);
        step();
        check({tag, " valid idle"}, read_valid, 0);
    endtask

    // Drives one burst; abort_at>0 aborts together with that accepted beat.
    task automatic run_load(input int base, input int count, input int abort_at, input int stall_pct);
        int acc = 0;
        int cyc = 0;
        logic v, ab;
        logic [W-1:0] d;
        load_start = 1'b1;
        load_base  = AW'(base);
        load_count = (AW + 1)'(count);
        step();
        load_start = 1'b0;
        ref_csum   = '0;
        if (count == 0) begin
            check("zero done", load_done, 1);
            check("zero ready", s_ready, 0);
            check("zero busy", load_busy, 0);
            step();
            check("zero done end", load_done, 0);
            check("zero ready end", s_ready, 0);
            check("zero csum", load_csum, exp_csum());
            return;
        end
        while (acc < count) begin
            if (cyc > 500) begin
                n_checks++;
                n_fail++;
                $display("FAIL load timeout: got %0d beats expected %0d", acc, count);
                break;
            end
            check("load busy", load_busy, 1);
            check("load ready", s_ready, 1);
            v = $urandom_range(99) >= stall_pct;
            d = $urandom;
            if (v && word_src.size() > 0) d = word_src.pop_front();
            ab = v && abort_at > 0 && acc + 1 == abort_at;
            s_valid    = v;
            s_data     = d;
            load_abort = ab;
            load_start = 1'($urandom_range(1));
            load_base  = AW'($urandom_range(CAP - 1));
            load_count = (AW + 1)'($urandom_range(CAP));
            step();
            cyc++;
            s_valid    = 1'b0;
            load_abort = 1'b0;
            load_start = 1'b0;
            if (v) begin
                ref_mem[(base + acc) % CAP] = d;
                ref_csum ^= d;
                acc++;
            end
            if (ab) begin
                check("abort busy", load_busy, 0);
                check("abort done", load_done, 0);
                check("abort csum", load_csum, exp_csum());
                step();
                check("abort no done", load_done, 0);
                return;
            end
        end
        if (stall_pct == 0) check("busy cycles", cyc, count);
        check("done pulse", load_done, 1);
        check("done busy", load_busy, 0);
        check("done ready", s_ready, 0);
        check("done csum", load_csum, exp_csum());
        step();
        check("done end", load_done, 0);
        check("csum hold", load_csum, exp_csum());
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] old_w, new_w;
        tab[0] = '{addr: 0,  data: 32'd1, oob: 1'b0};
        tab[1] = '{addr: 1,  data: 32'd2, oob: 1'b0};
        tab[2] = '{addr: 2,  data: 32'd3, oob: 1'b0};
        tab[3] = '{addr: 3,  data: 32'd4, oob: 1'b0};
        tab[4] = '{addr: 10, data: 32'd0, oob: 1'b1};
        tab[5] = '{addr: 15, data: 32'd0, oob: 1'b1};
        rst_n = 1'b1; load_start = 1'b0; load_abort = 1'b0; s_valid = 1'b0;
        read_en = 1'b0; load_base = '0; load_count = '0; s_data = '0; read_addr = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst ready", s_ready, 0);
        check("rst busy", load_busy, 0);
        check("rst done", load_done, 0);
        check("rst rvalid", read_valid, 0);
        check("rst oob", read_oob, 0);
        check("rst rdata", read_data, 0);
        check("rst csum", load_csum, 0);
        step();
        rst_n = 1'b1;
        step();

        run_load(0, CAP, 0, 0);
        sweep("fill");

        for (int i = 0; i < 4; i++) word_src.push_back(W'(i + 1));
        run_load(0, 4, 0, 0);
        for (int i = 0; i < 6; i++) fetch(tab[i].addr, tab[i].data, tab[i].oob, "table");

        load_abort = 1'b1;
        step();
        load_abort = 1'b0;
        check("idle abort busy", load_busy, 0);
        check("idle abort done", load_done, 0);

        run_load(8, 4, 0, 20);
        sweep("wrap");
        run_load(3, 0, 0, 0);
        sweep("zero");
        run_load(3, 5, 2, 30);
        sweep("abort");

        old_w = ref_mem[7];
        new_w = $urandom;
        load_start = 1'b1; load_base = AW'(7); load_count = (AW + 1)'(1);
        step();
        load_start = 1'b0;
        s_valid = 1'b1; s_data = new_w; read_en = 1'b1; read_addr = AW'(7);
        step();
        s_valid = 1'b0;
        check("rbw old", read_data, old_w);
        check("rbw valid", read_valid, 1);
        check("rbw done", load_done, 1);
        ref_mem[7] = new_w;
        ref_csum   = new_w;
        step();
        read_en = 1'b0;
        check("rbw new", read_data, new_w);
        check("rbw done end", load_done, 0);

        word_src.push_back(32'hA5A5A5A5);
        word_src.push_back(32'h0F0F0F0F);
        run_load(0, 2, 0, 0);
`ifdef IMEM_LOAD_CSUM_EN
        check("csum const", load_csum, 32'hAAAAAAAA);
`else
        check("csum const", load_csum, 32'h0);
`endif

        load_start = 1'b1; load_base = AW'(2); load_count = (AW + 1)'(3);
        step();
        load_start = 1'b0;
        new_w = $urandom;
        s_valid = 1'b1; s_data = new_w;
        step();
        s_valid = 1'b0;
        ref_mem[2] = new_w;
        rst_n = 1'b0;
        #1;
        check("mid rst busy", load_busy, 0);
        check("mid rst csum", load_csum, 0);
        check("mid rst rvalid", read_valid, 0);
        step();
        rst_n = 1'b1;
        step();
        sweep("mid rst");

        for (int k = 0; k < 6; k++) begin
            int b, c, ab;
            b  = $urandom_range(CAP - 1);
            c  = $urandom_range(CAP);
            ab = (c > 0 && $urandom_range(2) == 0) ? $urandom_range(c, 1) : 0;
            run_load(b, c, ab, $urandom_range(50));
            fetch(CAP, 0, 1'b1, "rand oob");
        end
        sweep("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter CAPACITY, default 512, instruction word count, SHALL be >= 2.
REQ-002 Parameter BUS_WIDTH, default 32, SHALL set the instruction word width in bits.
REQ-003 Localparam ADDR_WIDTH SHALL equal $clog2(CAPACITY), derived and not overridable.
REQ-004 Ports: clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 Ports: rst_n  in  1  asynchronous, active-low reset.
REQ-006 Ports: load_start  in  1  begin a load burst, sampled in IDLE only.
REQ-007 Ports: load_base  in  ADDR_WIDTH  first write address, captured with load_start.
REQ-008 Ports: load_count  in  ADDR_WIDTH+1  words to load (0..CAPACITY), captured with load_start.
REQ-009 Ports: load_abort  in  1  terminate the burst in progress.
REQ-010 Ports: s_valid  in  1  loader stream word valid.
REQ-011 Ports: s_data  in  BUS_WIDTH  loader stream word.
REQ-012 Ports: s_ready  out  1  block accepts a stream word this cycle.
REQ-013 Ports: load_busy  out  1  high while in LOAD.
REQ-014 Ports: load_done  out  1  one-cycle pulse on completed burst.
REQ-015 Ports: load_csum  out  BUS_WIDTH  XOR checksum of the last burst.
REQ-016 Ports: read_en  in  1  fetch request.
REQ-017 Ports: read_addr  in  ADDR_WIDTH  fetch word address.
REQ-018 Ports: read_data  out  BUS_WIDTH  fetched word, registered.
REQ-019 Ports: read_valid  out  1  read_data is valid this cycle.
REQ-020 Ports: read_oob  out  1  fetch address was >= CAPACITY, aligned with read_valid.

Function
REQ-021 FSM states SHALL be IDLE, LOAD and DONE.
REQ-022 IDLE->LOAD on load_start with load_count != 0; IDLE->DONE on load_start with load_count == 0, with no write.
REQ-023 In LOAD s_ready SHALL be 1; s_ready SHALL be 0 in every other state.
REQ-024 Each s_valid&s_ready beat SHALL write s_data to mem[wptr], then increment wptr and decrement the remaining count.
REQ-025 wptr SHALL wrap from CAPACITY-1 to 0, including when CAPACITY is not a power of two.
REQ-026 Final beat (remaining == 1) SHALL move LOAD->DONE.
REQ-027 DONE SHALL last exactly one cycle with load_done=1, then return to IDLE.
REQ-028 load_abort in LOAD SHALL move to IDLE next cycle without a load_done pulse; beats already written are retained.
REQ-029 load_abort on the same cycle as an accepted beat SHALL still write that beat.
REQ-030 load_start outside IDLE SHALL be ignored; load_abort outside LOAD SHALL be ignored.
REQ-031 Fetch latency SHALL be 1 cycle: read_valid=read_en delayed one cycle, read_data=mem[read_addr] as sampled.
REQ-032 Fetch and write to the same address in one cycle SHALL return the old word (read-before-write).
REQ-033 An out-of-range fetch (read_addr >= CAPACITY) SHALL return read_data=0 with read_oob=1.
REQ-034 Fetches SHALL be served in every FSM state.

Reset
REQ-035 rst_n low SHALL force state IDLE, wptr=0, remaining=0, s_ready=0, load_busy=0, load_done=0, read_valid=0, read_oob=0, read_data=0, load_csum=0.
REQ-036 Memory contents SHALL NOT be reset; reset during LOAD keeps words already written.

Configuration
REQ-037 With IMEM_LOAD_CSUM_EN defined, load_csum SHALL clear on the accepted load_start and XOR in every accepted beat; it holds after DONE or abort until the next start.
REQ-038 Without IMEM_LOAD_CSUM_EN, load_csum SHALL be constant 0 and no checksum register is built.

Structure
REQ-039 Package imem_pkg SHALL hold the FSM state typedef (imem_state_t) and default constants IMEM_DEF_CAPACITY=512 and IMEM_DEF_WIDTH=32.
REQ-040 Storage SHALL live in sub-module imem_array: one synchronous write port and one registered read port, parametrised by CAPACITY and BUS_WIDTH.

Verification
REQ-041 Reset, then load_base=0, load_count=4, words 1,2,3,4 with no stalls -> load_busy for 4 cycles, load_done pulse, fetches of 0..3 return 1..4 one cycle later.
REQ-042 CAPACITY=10, load_base=8, load_count=4 -> writes land at 8,9,0,1.
REQ-043 load_count=0 -> load_done one cycle after start, no writes, s_ready never 1.
REQ-044 Abort after 2 of 5 beats -> IDLE, no load_done, addresses base and base+1 updated and the rest unchanged.
REQ-045 Fetch and write at address 7 in the same cycle -> old word returned, new word returned on the next fetch; read_addr=CAPACITY (non-power-of-two) -> read_oob=1, read_data=0.
REQ-046 With IMEM_LOAD_CSUM_EN, words 0xA5A5A5A5 and 0x0F0F0F0F -> load_csum=0xAAAAAAAA; without it -> 0.
